// File: rtl/gige_mac_pkg.sv
// Shared constants, status word layout and receive FSM encoding for the GigE MAC.
package gige_mac_pkg;

    localparam logic [63:0] GIGE_PREAMBLE = 64'hd555_5555_5555_55fb;
    localparam logic [47:0] PAUSE_DA      = 48'h0100_00c2_8001;
    localparam logic [31:0] PAUSE_TYPE_OP = 32'h0100_0888;

    localparam int STS_ERR   = 16;
    localparam int STS_RUNT  = 17;
    localparam int STS_OVS   = 18;
    localparam int STS_TRUNC = 19;
    localparam int STS_PAUSE = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DROP  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/gige_rx_pause_det.sv
// PAUSE frame recogniser: DA/type-opcode compare, quanta capture and the
// rx_pause/rx_pack handshake register toward the transmit encapsulator.
module gige_rx_pause_det
    import gige_mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_acc,
    input  logic        i_eop,
    input  logic        i_err,
    input  logic [63:0] i_wdata,
    input  logic        i_pack,
    output logic        o_pause_frm,
    output logic        o_pause_drop,
    output logic        o_pause,
    output logic [15:0] o_pvalue
);

    logic [1:0]  r_idx;
    logic        r_da_ok;
    logic        r_is_pause;
    logic        r_drop;
    logic        r_pause;
    logic [15:0] r_pv_cand;
    logic [15:0] r_pvalue;

    logic        w_da_match;
    logic        w_to_match;
    logic        w_pause_frm;
    logic        w_issue;
    logic [15:0] w_pv;

    assign w_da_match  = (i_wdata[47:0] == PAUSE_DA);
    assign w_to_match  = (i_wdata[63:32] == PAUSE_TYPE_OP);
    // Verdict is combinational while w1 is on the bus so w0 can be held back that same cycle.
    assign w_pause_frm = (i_acc && r_idx == 2'd1) ? (r_da_ok & w_to_match) : r_is_pause;
    assign w_pv        = (r_idx == 2'd2) ? {i_wdata[7:0], i_wdata[15:8]} : r_pv_cand;
    assign w_issue     = i_acc & i_eop & w_pause_frm & ~i_err & r_idx[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_da_ok    <= 1'b0;
            r_is_pause <= 1'b0;
            r_drop     <= 1'b0;
            r_pv_cand  <= '0;
        end else if (i_start) begin
            r_idx      <= '0;
            r_da_ok    <= 1'b0;
            r_is_pause <= 1'b0;
            r_drop     <= 1'b0;
        end else if (i_acc) begin
            if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd0) r_da_ok <= w_da_match;
            if (r_idx == 2'd1) r_is_pause <= r_da_ok & w_to_match;
            if (r_idx == 2'd2) r_pv_cand <= w_pv;
            if (i_eop) r_drop <= w_pause_frm & ~w_issue;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pause  <= 1'b0;
            r_pvalue <= '0;
        end else if (w_issue) begin
            r_pause  <= 1'b1;
            r_pvalue <= w_pv;
        end else if (i_pack) begin
            r_pause  <= 1'b0;
        end
    end

    assign o_pause_frm  = w_pause_frm;
    assign o_pause_drop = r_drop;
    assign o_pause      = r_pause;
    assign o_pvalue     = r_pvalue;

endmodule

// File: rtl/gige_rx_decap.sv
// GigE receive decapsulator: strips the preamble word, writes frame data and one
// status word per frame to the RX FIFOs, and hands PAUSE quanta to the TX side.
//   state | meaning
//   IDLE  | wait for sop carrying a valid preamble
//   HDR   | take w0 into the hold register
//   DATA  | write held word, hold the new one
//   FLUSH | write last held word plus status
//   DROP  | discard words until eop
module gige_rx_decap
    import gige_mac_pkg::*;
#(
    parameter int unsigned MIN_BYTES = 60,
    parameter int unsigned MAX_BYTES = 1514,
    parameter bit          PAUSE_FWD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_wvld,
    input  logic [63:0] rx_wdata,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [2:0]  rx_ebytes,
    input  logic        rx_err,
    input  logic        rxfifo_full,
    output logic        rxfifo_wr_en,
    output logic [63:0] rxfifo_din,
    input  logic        rxsts_full,
    output logic        rxsts_wr_en,
    output logic [31:0] rxsts_din,
    output logic        rx_pause,
    output logic [15:0] rx_pvalue,
    input  logic        rx_pack,
    output logic [15:0] rx_frm_cnt,
    output logic [15:0] rx_drop_cnt
);

    localparam logic [15:0] MIN_B = 16'(MIN_BYTES);
    localparam logic [15:0] MAX_B = 16'(MAX_BYTES);

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [63:0] r_hold;
    logic        r_hold_wr;
    logic [15:0] r_count;
    logic        r_err;
    logic        r_ovs;
    logic        r_trunc;
    logic [15:0] r_frm_cnt;
    logic [15:0] r_drop_cnt;

    logic        w_sop_in;
    logic        w_pre_ok;
    logic        w_acc;
    logic        w_start;
    logic        w_supp;
    logic        w_wr_try;
    logic        w_sts_wr;
    logic [1:0]  w_drop_inc;
    logic [15:0] w_add;
    logic [15:0] w_cnt_nxt;
    logic        w_pause_frm;
    logic        w_pause_drop;
    logic [31:0] w_sts;

    assign w_sop_in  = rx_wvld & rx_sop;
    assign w_pre_ok  = (rx_wdata == GIGE_PREAMBLE) & ~rx_eop & ~rxsts_full;
    assign w_start   = (r_state == ST_IDLE) & w_sop_in & w_pre_ok;
    assign w_acc     = rx_wvld & ((r_state == ST_HDR) | (r_state == ST_DATA));
    assign w_add     = (rx_eop && rx_ebytes != 3'd0) ? {13'd0, rx_ebytes} : 16'd8;
    assign w_cnt_nxt = r_count + w_add;
    assign w_supp    = ~PAUSE_FWD & w_pause_frm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_sop_in) w_state_nxt = w_pre_ok ? ST_HDR : (rx_eop ? ST_IDLE : ST_DROP);
            ST_HDR:   if (rx_wvld) w_state_nxt = rx_eop ? ST_FLUSH : ST_DATA;
            ST_DATA:  if (rx_wvld && rx_eop) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = (w_sop_in && !rx_eop) ? ST_DROP : ST_IDLE;
            ST_DROP:  if (rx_wvld && rx_eop) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wr_try   = 1'b0;
        w_sts_wr   = 1'b0;
        w_drop_inc = 2'd0;
        case (r_state)
            ST_IDLE:  w_drop_inc = {1'b0, w_sop_in & ~w_pre_ok};
            ST_DATA:  w_wr_try   = rx_wvld & r_hold_wr & ~w_supp;
            ST_FLUSH: begin
                w_wr_try   = r_hold_wr & ~w_supp;
                w_sts_wr   = ~w_supp;
                // A consumed-but-invalid PAUSE and a sop landing in FLUSH can both count here.
                w_drop_inc = {1'b0, w_supp & w_pause_drop} + {1'b0, w_sop_in};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_sts            = '0;
        w_sts[15:0]      = r_count;
        w_sts[STS_ERR]   = r_err;
        w_sts[STS_RUNT]  = (r_count < MIN_B);
        w_sts[STS_OVS]   = r_ovs;
        w_sts[STS_TRUNC] = r_trunc | (w_wr_try & rxfifo_full);
        w_sts[STS_PAUSE] = w_pause_frm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold     <= '0;
            r_hold_wr  <= 1'b0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_ovs      <= 1'b0;
            r_trunc    <= 1'b0;
            r_frm_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_start) begin
                r_hold_wr <= 1'b0;
                r_count   <= '0;
                r_err     <= 1'b0;
                r_ovs     <= 1'b0;
                r_trunc   <= 1'b0;
            end else if (w_acc) begin
                r_hold    <= rx_wdata;
                r_hold_wr <= (r_count < MAX_B);
                r_count   <= w_cnt_nxt;
                if (w_cnt_nxt > MAX_B) r_ovs <= 1'b1;
                if (rx_eop) r_err <= rx_err;
                if (w_wr_try && rxfifo_full) r_trunc <= 1'b1;
            end
            if (w_sts_wr && r_frm_cnt != 16'hffff) r_frm_cnt <= r_frm_cnt + 16'd1;
            if (r_drop_cnt > 16'hffff - {14'd0, w_drop_inc}) r_drop_cnt <= 16'hffff;
            else                                             r_drop_cnt <= r_drop_cnt + {14'd0, w_drop_inc};
        end
    end

    gige_rx_pause_det u_pause_det (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_acc        (w_acc),
        .i_eop        (rx_eop),
        .i_err        (rx_err),
        .i_wdata      (rx_wdata),
        .i_pack       (rx_pack),
        .o_pause_frm  (w_pause_frm),
        .o_pause_drop (w_pause_drop),
        .o_pause      (rx_pause),
        .o_pvalue     (rx_pvalue)
    );

    assign rxfifo_wr_en = w_wr_try & ~rxfifo_full;
    assign rxfifo_din   = r_hold;
    assign rxsts_wr_en  = w_sts_wr;
    assign rxsts_din    = w_sts_wr ? w_sts : 32'd0;
    assign rx_frm_cnt   = r_frm_cnt;
    assign rx_drop_cnt  = r_drop_cnt;

endmodule
